sbox_arbiter: RTL and testbench

Time-multiplexes one registered AES S-box ROM (8-bit address in, 8-bit data out, fixed read latency) between two requesters: the round datapath, which needs SubBytes on a 128-bit state, and the key-schedule unit, which needs SubWord on a 32-bit word. Both requesters own no S-box of their own. This block arbitrates between them, streams the granted job byte-serially through the shared ROM at one byte per cycle, reassembles the substituted result, and returns it with a done pulse. It sits between the AES core control and the external S-box instance.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/sbox_arbiter_if.sv | 26 ++
 rtl/sbox_tag_pipe.sv | 35 +++
 rtl/sbox_arbiter.sv | 141 ++++++++++++++
 tb/tb_sbox_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants, FSM state and grant types for the S-box arbiter
package aes_pkg;

    localparam int ST_BYTES = 16;
    localparam int KS_BYTES = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_ST = 1'b0,
        GNT_KS = 1'b1
    } grant_t;

    // Index of the last byte of a job for the given requester.
    function automatic logic [3:0] job_last_idx(input grant_t g);
        return (g == GNT_KS) ? 4'(KS_BYTES - 1) : 4'(ST_BYTES - 1);
    endfunction

endpackage

// File: rtl/sbox_arbiter_if.sv
// rtl/sbox_arbiter_if.sv - requester and shared S-box signals of the arbiter
interface sbox_arbiter_if;

    logic         st_req;
    logic [127:0] st_din;
    logic         st_done;
    logic [127:0] st_dout;
    logic         ks_req;
    logic [31:0]  ks_din;
    logic         ks_done;
    logic [31:0]  ks_dout;
    logic         busy;
    logic [7:0]   sb_a;
    logic [7:0]   sb_q;

    modport slave (
        input  st_req, st_din, ks_req, ks_din, sb_q,
        output st_done, st_dout, ks_done, ks_dout, busy, sb_a
    );

    modport master (
        output st_req, st_din, ks_req, ks_din, sb_q,
        input  st_done, st_dout, ks_done, ks_dout, busy, sb_a
    );

endinterface

// File: rtl/sbox_tag_pipe.sv
// rtl/sbox_tag_pipe.sv - valid plus byte-index delay line matching the S-box read latency
module sbox_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_valid,
    input  logic [3:0] i_idx,
    output logic       o_valid,
    output logic [3:0] o_idx
);

    logic [DEPTH-1:0] r_valid;
    logic [3:0]       r_idx [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_idx[0]   <= i_idx;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_idx[i]   <= r_idx[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];

endmodule

// File: rtl/sbox_arbiter.sv
// rtl/sbox_arbiter.sv - round-robin sharing of one registered S-box between SubBytes and SubWord jobs
module sbox_arbiter
    import aes_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    sbox_arbiter_if.slave bus
);

    localparam logic [1:0] DRAIN_LAST = 2'(SBOX_LAT - 1);

    state_t       r_state;
    state_t       w_next;
    grant_t       r_grant;
    grant_t       r_last_grant;
    grant_t       w_pick;
    logic [3:0]   r_idx;
    logic [3:0]   r_last_idx;
    logic [1:0]   r_drain;
    logic [127:0] r_work;
    logic [127:0] r_st_dout;
    logic [31:0]  r_ks_dout;

    logic         w_accept;
    logic         w_issue;
    logic [7:0]   w_sb_a;
    logic         w_st_done;
    logic         w_ks_done;
    logic         w_tag_valid;
    logic [3:0]   w_tag_idx;

    // On a tie, the requester not served last wins.
    always_comb begin
        w_pick = GNT_ST;
        if (bus.st_req && bus.ks_req) begin
            w_pick = (r_last_grant == GNT_ST) ? GNT_KS : GNT_ST;
        end else if (bus.ks_req) begin
            w_pick = GNT_KS;
        end
    end

    assign w_accept = (r_state == S_IDLE) && (bus.st_req || bus.ks_req);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_issue   = 1'b0;
        w_sb_a    = 8'h00;
        w_st_done = 1'b0;
        w_ks_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue = 1'b1;
                w_sb_a  = r_work[{r_idx, 3'b000} +: 8];
                if (r_idx == r_last_idx) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_st_done = (r_grant == GNT_ST);
                w_ks_done = (r_grant == GNT_KS);
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    sbox_tag_pipe #(
        .DEPTH (SBOX_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (w_issue),
        .i_idx   (r_idx),
        .o_valid (w_tag_valid),
        .o_idx   (w_tag_idx)
    );

    // Grant is stable until the next accept, so late captures land in the right register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant      <= GNT_ST;
            r_last_grant <= GNT_ST;
            r_idx        <= '0;
            r_last_idx   <= '0;
            r_drain      <= '0;
            r_work       <= '0;
            r_st_dout    <= '0;
            r_ks_dout    <= '0;
        end else begin
            if (w_accept) begin
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
                r_last_idx   <= job_last_idx(w_pick);
                r_idx        <= '0;
                r_work       <= (w_pick == GNT_KS) ? {96'b0, bus.ks_din} : bus.st_din;
            end else if (w_issue) begin
                r_idx <= r_idx + 4'd1;
            end

            r_drain <= (r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;

            if (w_tag_valid) begin
                if (r_grant == GNT_ST) begin
                    r_st_dout[{w_tag_idx, 3'b000} +: 8] <= bus.sb_q;
                end else begin
                    r_ks_dout[{w_tag_idx[1:0], 3'b000} +: 8] <= bus.sb_q;
                end
            end
        end
    end

    assign bus.sb_a    = w_sb_a;
    assign bus.st_done = w_st_done;
    assign bus.ks_done = w_ks_done;
    assign bus.st_dout = r_st_dout;
    assign bus.ks_dout = r_ks_dout;
    assign bus.busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_sbox_arbiter.sv
// tb/tb_sbox_arbiter.sv - scoreboard bench for sbox_arbiter at read latency 1 and 2
module tb_sbox_arbiter;

    localparam logic [2047:0] SBOX_P = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] DIN_0F = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] EXP_0F = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [127:0] DIN_1F = 128'h1f1e1d1c1b1a19181716151413121110;
    localparam logic [127:0] EXP_1F = 128'hc072a49cafa2d4adf04759fa7dc982ca;
    localparam logic [127:0] EXP_63 = {16{8'h63}};

    typedef struct {
        logic         is_ks;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic   clk;
    logic   reset_n;
    int     cyc;
    int     checks;
    int     failures;
    int     e0;
    exp_t   q1[$];
    exp_t   q2[$];
    logic [7:0] r_rom2;

    sbox_arbiter_if bus1 ();
    sbox_arbiter_if bus2 ();

    sbox_arbiter #(.SBOX_LAT(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    sbox_arbiter #(.SBOX_LAT(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [2047:0] t;
        t = SBOX_P;
        return t[2047 - 8 * int'(a) -: 8];
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        bus1.sb_q <= sbox(bus1.sb_a);
        r_rom2    <= sbox(bus2.sb_a);
        bus2.sb_q <= r_rom2;
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic mon(input int id, input logic st_done, input logic ks_done,
                       input logic [127:0] st_dout, input logic [31:0] ks_dout);
        exp_t e;
        if (!(st_done || ks_done)) return;
        if (st_done && ks_done) begin
            chk($sformatf("dut%0d_both_done", id), 128'd1, 128'd0);
        end
        if ((id == 1 && q1.size() == 0) || (id == 2 && q2.size() == 0)) begin
            chk($sformatf("dut%0d_unexpected_done cyc=%0d", id, cyc), 128'd1, 128'd0);
            return;
        end
        e = (id == 1) ? q1.pop_front() : q2.pop_front();
        chk($sformatf("dut%0d_done_requester", id), {127'd0, ks_done}, {127'd0, e.is_ks});
        chk($sformatf("dut%0d_done_cycle", id), 128'(cyc), 128'(e.cyc));
        chk($sformatf("dut%0d_dout", id), ks_done ? {96'd0, ks_dout} : st_dout, e.data);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            mon(1, bus1.st_done, bus1.ks_done, bus1.st_dout, bus1.ks_dout);
            mon(2, bus2.st_done, bus2.ks_done, bus2.st_dout, bus2.ks_dout);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic is_ks, input logic [127:0] data, input int at);
        exp_t e;
        e.is_ks = is_ks;
        e.data  = data;
        e.cyc   = at;
        q1.push_back(e);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus1.st_req = 1'b0; bus1.st_din = '0; bus1.ks_req = 1'b0; bus1.ks_din = '0;
        bus2.st_req = 1'b0; bus2.st_din = '0; bus2.ks_req = 1'b0; bus2.ks_din = '0;
        repeat (3) tick();
        chk("reset_st_dout", bus1.st_dout, '0);
        chk("reset_ks_dout", {96'd0, bus1.ks_dout}, '0);
        chk("reset_st_done", {127'd0, bus1.st_done}, '0);
        chk("reset_ks_done", {127'd0, bus1.ks_done}, '0);
        chk("reset_busy", {127'd0, bus1.busy}, '0);
        chk("reset_sb_a", {120'd0, bus1.sb_a}, '0);
        reset_n = 1'b1;
        tick();

        // Tie on the first request: ks, then st, then ks again.
        bus1.st_req = 1'b1; bus1.ks_req = 1'b1;
        tick();
        e0 = cyc;
        push1(1'b1, {96'd0, 32'h63636363}, e0 + 5);
        push1(1'b0, EXP_63, e0 + 24);
        push1(1'b1, {96'd0, 32'h63636363}, e0 + 31);
        repeat (31) tick();
        bus1.st_req = 1'b0; bus1.ks_req = 1'b0;
        repeat (4) tick();

        // st alone
        bus1.st_din = DIN_0F; bus1.st_req = 1'b1;
        tick();
        e0 = cyc;
        push1(1'b0, EXP_0F, e0 + 17);
        repeat (2) tick();
        bus1.st_req = 1'b0;
        tick();
        chk("st_busy_mid", {127'd0, bus1.busy}, 128'd1);
        chk("st_sb_a_idx3", {120'd0, bus1.sb_a}, 128'h03);
        repeat (15) tick();
        chk("st_busy_after", {127'd0, bus1.busy}, '0);
        chk("st_sb_a_idle", {120'd0, bus1.sb_a}, '0);

        // ks alone
        bus1.ks_din = 32'hcf4f3c09; bus1.ks_req = 1'b1;
        tick();
        e0 = cyc;
        bus1.ks_req = 1'b0;
        push1(1'b1, {96'd0, 32'h8a84eb01}, e0 + 5);
        repeat (6) tick();
        chk("ks_leaves_st_dout", bus1.st_dout, EXP_0F);

        // st dropped one cycle after accept
        bus1.st_din = DIN_1F; bus1.st_req = 1'b1;
        tick();
        e0 = cyc;
        push1(1'b0, EXP_1F, e0 + 17);
        tick();
        bus1.st_req = 1'b0;
        repeat (22) tick();

        // Reset in the middle of an st job
        bus1.st_din = DIN_0F; bus1.st_req = 1'b1;
        tick();
        bus1.st_req = 1'b0;
        repeat (8) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_st_dout", bus1.st_dout, '0);
        chk("abort_ks_dout", {96'd0, bus1.ks_dout}, '0);
        chk("abort_busy", {127'd0, bus1.busy}, '0);
        chk("abort_sb_a", {120'd0, bus1.sb_a}, '0);
        chk("abort_st_done", {127'd0, bus1.st_done}, '0);
        tick();
        reset_n = 1'b1;
        tick();
        bus1.ks_din = 32'h00010203; bus1.ks_req = 1'b1;
        tick();
        e0 = cyc;
        bus1.ks_req = 1'b0;
        push1(1'b1, {96'd0, 32'h637c777b}, e0 + 5);
        repeat (24) tick();
        chk("post_abort_st_dout", bus1.st_dout, '0);

        // Two-cycle S-box latency
        bus2.st_din = DIN_0F; bus2.st_req = 1'b1;
        tick();
        e0 = cyc;
        bus2.st_req = 1'b0;
        begin
            exp_t e;
            e.is_ks = 1'b0;
            e.data  = EXP_0F;
            e.cyc   = e0 + 18;
            q2.push_back(e);
        end
        repeat (22) tick();

        chk("q1_drained", 128'(q1.size()), '0);
        chk("q2_drained", 128'(q2.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
